// File: rtl/rstx_feeder_01a_pkg.sv
// ---------------------------------------------------------------------------
// rstx_feeder_01a_pkg
// Shared definitions for the serial-transmit feeder: FSM state codes and the
// default FIFO depth / start-acknowledge timeout. Also used by the
// transmitter-side testbench so both sides agree on the defaults.
// ---------------------------------------------------------------------------
package rstx_feeder_01a_pkg;

  // Issue sequencer states; codes are fixed so they can be probed on a scope.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_TRIG       = 2'b01,
    ST_WAIT_START = 2'b10,
    ST_WAIT_DONE  = 2'b11
  } fsm_state_e;

  localparam int unsigned DEF_DEPTH_LOG2  = 4;     // 16-entry byte FIFO
  localparam int unsigned DEF_ACK_TIMEOUT = 1023;  // F25Clk cycles in WAIT_START
  localparam int unsigned ACK_CNT_W       = 16;    // timeout counter width

endpackage

// File: rtl/rstx_feeder_01a_if.sv
// ---------------------------------------------------------------------------
// rstx_feeder_01a_if
// Bundles the byte-write side and the transmitter handshake side of the
// feeder.
//   slave  : view of the feeder itself (takes writes, drives tx signals)
//   master : view of the surrounding logic / testbench
// Signals:
//   wrData/wrEn            byte enqueue strobe
//   full/empty/level       FIFO occupancy
//   overflow/ovfClear      sticky dropped-write flag and its clear
//   txParallelData         byte held for the transmitter
//   txTrigger              one-clock start pulse
//   txStatus               transmitter busy (asynchronous to F25Clk)
//   busy/ackTimeout        sequencer activity and start-timeout pulse
// ---------------------------------------------------------------------------
interface rstx_feeder_01a_if
  import rstx_feeder_01a_pkg::*;
#(
  parameter int unsigned P_DEPTH_LOG2 = DEF_DEPTH_LOG2
);

  logic [7:0]            wrData;
  logic                  wrEn;
  logic                  full;
  logic                  empty;
  logic [P_DEPTH_LOG2:0] level;
  logic                  overflow;
  logic                  ovfClear;
  logic [7:0]            txParallelData;
  logic                  txTrigger;
  logic                  txStatus;
  logic                  busy;
  logic                  ackTimeout;

  modport slave (
    input  wrData, wrEn, ovfClear, txStatus,
    output full, empty, level, overflow, txParallelData, txTrigger, busy, ackTimeout
  );

  modport master (
    output wrData, wrEn, ovfClear, txStatus,
    input  full, empty, level, overflow, txParallelData, txTrigger, busy, ackTimeout
  );

endinterface

// File: rtl/rstx_feeder_01a_sync2.sv
// ---------------------------------------------------------------------------
// rs_sync2_01a
// Generic two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk    destination clock
//   rst_n  synchronous active-low reset (both stages clear to 0)
//   d_i    asynchronous input
//   q_o    synchronized output, two to three clk edges behind d_i
// ---------------------------------------------------------------------------
module rs_sync2_01a
  import rstx_feeder_01a_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/rstx_feeder_01a.sv
// ---------------------------------------------------------------------------
// rstx_feeder_01a
// Byte FIFO plus issue sequencer feeding the serial transmitter. Bytes are
// queued at F25Clk rate; one byte at a time is presented on txParallelData
// with a one-clock txTrigger, and no new byte is issued while the
// synchronized txStatus shows a frame in flight.
// Ports:
//   F25Clk   system clock, all state on its rising edge
//   reset_n  synchronous active-low reset
//   bus      rstx_feeder_01a_if.slave (write side + transmitter handshake)
// ---------------------------------------------------------------------------
module rstx_feeder_01a
  import rstx_feeder_01a_pkg::*;
#(
  parameter int unsigned P_DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int unsigned P_ACK_TIMEOUT = DEF_ACK_TIMEOUT
)(
  input  logic              F25Clk,
  input  logic              reset_n,
  rstx_feeder_01a_if.slave  bus
);

  localparam int unsigned            DEPTH     = 1 << P_DEPTH_LOG2;
  localparam logic [P_DEPTH_LOG2:0]  LVL_FULL  = {1'b1, {P_DEPTH_LOG2{1'b0}}};
  localparam logic [ACK_CNT_W-1:0]   ACK_LIMIT = ACK_CNT_W'(P_ACK_TIMEOUT);

  // ---------------- status synchronizer ----------------
  logic status_s;

  rs_sync2_01a u_status_sync (
    .clk   (F25Clk),
    .rst_n (reset_n),
    .d_i   (bus.txStatus),
    .q_o   (status_s)
  );

  // ---------------- FIFO ----------------
  logic [7:0]              mem_q [DEPTH];
  logic [P_DEPTH_LOG2-1:0] wr_ptr_q;
  logic [P_DEPTH_LOG2-1:0] rd_ptr_q;
  logic [P_DEPTH_LOG2:0]   level_q;
  logic [P_DEPTH_LOG2:0]   level_d;
  logic                    overflow_q;
  logic [7:0]              tx_data_q;
  logic                    full_w;
  logic                    empty_w;
  logic                    push;
  logic                    pop;
  logic                    wr_reject;

  fsm_state_e              state_q;
  fsm_state_e              state_d;
  logic [ACK_CNT_W-1:0]    ack_cnt_q;
  logic [ACK_CNT_W-1:0]    ack_cnt_d;

  assign full_w    = (level_q == LVL_FULL);
  assign empty_w   = (level_q == '0);
  // Fullness is judged on the registered level, so a pop in the same cycle
  // does not make room for a write that arrives while full.
  assign push      = bus.wrEn && !full_w;
  assign wr_reject = bus.wrEn && full_w;
  // Popping only from stored entries means a write into an empty FIFO is
  // never forwarded straight to the transmitter in the same cycle.
  assign pop       = (state_q == ST_IDLE) && !empty_w && !status_s;

  // Storage has no reset so it maps onto distributed/block RAM.
  always_ff @(posedge F25Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wrData;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge F25Clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      level_q <= level_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      // The transmitter samples this byte in its own clock domain, so it only
      // changes on a pop and stays put for the whole frame.
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        tx_data_q <= mem_q[rd_ptr_q];
      end
      // Set has priority over clear so a drop is never lost.
      if (wr_reject) begin
        overflow_q <= 1'b1;
      end else if (bus.ovfClear) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // ---------------- issue sequencer: state register ----------------
  always_ff @(posedge F25Clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ack_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

  // ---------------- issue sequencer: next state ----------------
  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_TRIG;
        end
      end
      ST_TRIG: begin
        ack_cnt_d = '0;
        state_d   = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        // An acknowledge arriving on the timeout cycle still counts.
        if (status_s) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt_q == ACK_LIMIT) begin
          state_d = ST_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!status_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- issue sequencer: outputs ----------------
  // Decoded only from registers (state, counter, synchronized status), so
  // there is no combinational path from any input pin.
  always_comb begin
    bus.txTrigger  = (state_q == ST_TRIG);
    bus.busy       = (state_q != ST_IDLE);
    bus.ackTimeout = (state_q == ST_WAIT_START) && !status_s && (ack_cnt_q == ACK_LIMIT);
  end

  assign bus.full           = full_w;
  assign bus.empty          = empty_w;
  assign bus.level          = level_q;
  assign bus.overflow       = overflow_q;
  assign bus.txParallelData = tx_data_q;

endmodule

// File: tb/tb_rstx_feeder_01a.sv
module tb_rstx_feeder_01a;

  localparam int DL2    = 4;
  localparam int DEPTH  = 16;
  localparam int ACK_TO = 20;

  localparam int M_ACK   = 0;
  localparam int M_HOLD  = 1;
  localparam int M_NOACK = 2;

  logic clk = 1'b0;
  logic reset_n;

  rstx_feeder_01a_if #(.P_DEPTH_LOG2(DL2)) bus ();

  rstx_feeder_01a #(.P_DEPTH_LOG2(DL2), .P_ACK_TIMEOUT(ACK_TO)) dut (
    .F25Clk  (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  // reference model: ordered byte queue, occupancy, sticky overflow
  logic [7:0] exp_q [$];
  int   mdl_level = 0;
  logic mdl_ovf   = 1'b0;

  int   cyc = 0;
  int   last_trig_cyc = 0;
  int   n_trig = 0;
  int   n_ack = 0;
  logic prev_trig = 1'b0;
  logic prev_ack  = 1'b0;

  // inputs as seen at the last rising edge, and a 2-stage status delay model
  logic       cap_rst  = 1'b0;
  logic       cap_wren = 1'b0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_clr  = 1'b0;
  logic       sh1 = 1'b0, sh2 = 1'b0, sh2_prev = 1'b0;

  // transmitter status model
  int mode       = M_NOACK;
  int resp_delay = 1;
  int resp_hold  = 10;
  int resp_phase = 0;
  int resp_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    bus.wrEn   = 1'b1;
    bus.wrData = d;
    tick(1);
    bus.wrEn   = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !bus.busy && bus.empty && resp_phase == 0 && !bus.txStatus)
           && n < bound) begin
      tick(1);
      n++;
    end
    chk({nm, "_drain_in_time"}, 32'(n < bound), 1);
  endtask

  // ---------------- edge capture ----------------
  initial begin
    forever begin
      @(posedge clk);
      cap_rst  = reset_n;
      cap_wren = bus.wrEn;
      cap_data = bus.wrData;
      cap_clr  = bus.ovfClear;
      sh2_prev = sh2;
      if (!reset_n) begin
        sh1 = 1'b0;
        sh2 = 1'b0;
      end else begin
        sh2 = sh1;
        sh1 = bus.txStatus;
      end
    end
  end

  // ---------------- transmitter status model ----------------
  initial begin
    bus.txStatus = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        M_HOLD: begin
          bus.txStatus = 1'b1;
          resp_phase   = 0;
        end
        M_NOACK: begin
          bus.txStatus = 1'b0;
          resp_phase   = 0;
        end
        default: begin
          case (resp_phase)
            0: begin
              bus.txStatus = 1'b0;
              if (bus.txTrigger) begin
                resp_cnt   = resp_delay;
                resp_phase = 1;
              end
            end
            1: begin
              if (resp_cnt == 0) begin
                bus.txStatus = 1'b1;
                resp_cnt     = resp_hold;
                resp_phase   = 2;
              end else begin
                resp_cnt--;
              end
            end
            default: begin
              if (resp_cnt == 0) begin
                bus.txStatus = 1'b0;
                resp_phase   = 0;
              end else begin
                resp_cnt--;
              end
            end
          endcase
        end
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int         pre_level;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      cyc++;
      if (!cap_rst) begin
        exp_q.delete();
        mdl_level = 0;
        mdl_ovf   = 1'b0;
        chk("rst_level",    32'(bus.level), 0);
        chk("rst_empty",    32'(bus.empty), 1);
        chk("rst_full",     32'(bus.full), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        chk("rst_txdata",   32'(bus.txParallelData), 0);
        chk("rst_trigger",  32'(bus.txTrigger), 0);
        chk("rst_busy",     32'(bus.busy), 0);
        chk("rst_ackto",    32'(bus.ackTimeout), 0);
      end else begin
        pre_level = mdl_level;
        if (bus.ackTimeout) begin
          n_ack++;
          $display("ACKTIMEOUT cycle=%0d", cyc);
          chk("ack_latency", 32'(cyc - last_trig_cyc), ACK_TO + 1);
          chk("ack_one_cycle", 32'(prev_ack), 0);
        end
        if (bus.txTrigger) begin
          n_trig++;
          $display("TX byte=%02h cycle=%0d", bus.txParallelData, cyc);
          chk("trig_one_cycle", 32'(prev_trig), 0);
          chk("trig_status_s_low", 32'(sh2_prev), 0);
          chk("trig_busy", 32'(bus.busy), 1);
          if (exp_q.size() == 0) begin
            chk("trig_unexpected_qsize", 32'(exp_q.size()), 1);
          end else begin
            exp_b = exp_q.pop_front();
            chk("trig_data", 32'(bus.txParallelData), 32'(exp_b));
          end
          mdl_level--;
          last_trig_cyc = cyc;
        end
        if (cap_wren) begin
          if (pre_level < DEPTH) begin
            exp_q.push_back(cap_data);
            mdl_level++;
          end else begin
            mdl_ovf = 1'b1;
          end
        end
        if (!(cap_wren && pre_level >= DEPTH) && cap_clr) mdl_ovf = 1'b0;
        chk("level",    32'(bus.level), 32'(mdl_level));
        chk("full",     32'(bus.full), 32'(mdl_level == DEPTH));
        chk("empty",    32'(bus.empty), 32'(mdl_level == 0));
        chk("overflow", 32'(bus.overflow), 32'(mdl_ovf));
      end
      prev_trig = bus.txTrigger;
      prev_ack  = bus.ackTimeout;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    n_bad++;
    $display("FAIL watchdog: got no end of test expected finish before 60000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int t0;
    reset_n      = 1'b0;
    bus.wrEn     = 1'b0;
    bus.wrData   = 8'h00;
    bus.ovfClear = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // single byte, write-to-trigger latency and busy release
    mode = M_ACK; resp_delay = 2; resp_hold = 200;
    bus.wrEn = 1'b1; bus.wrData = 8'hA5;
    tick(1);
    bus.wrEn = 1'b0;
    @(negedge clk);
    chk("t1_empty_after_write", 32'(bus.empty), 0);
    chk("t1_no_trig_yet", 32'(bus.txTrigger), 0);
    @(negedge clk);
    chk("t1_trig_edge_n1", 32'(bus.txTrigger), 1);
    chk("t1_data", 32'(bus.txParallelData), 32'h A5);
    @(negedge clk);
    chk("t1_trig_dropped", 32'(bus.txTrigger), 0);
    n = 0;
    while (!bus.txStatus && n < 50) begin @(posedge clk); #3; n++; end
    chk("t1_status_rose", 32'(bus.txStatus), 1);
    n = 0;
    while (bus.txStatus && n < 400) begin @(posedge clk); #3; n++; end
    chk("t1_status_fell", 32'(bus.txStatus), 0);
    n = 0;
    while (bus.busy && n < 10) begin @(posedge clk); #1; n++; end
    chk("t1_busy_clear_le3", 32'(n <= 3 && !bus.busy), 1);
    wait_idle("t1", 200);

    // fill and overflow with the transmitter held busy
    mode = M_HOLD;
    tick(4);
    for (int i = 0; i < 16; i++) begin
      bus.wrEn = 1'b1; bus.wrData = 8'(i);
      tick(1);
    end
    bus.wrEn = 1'b0;
    @(negedge clk);
    chk("t2_level16", 32'(bus.level), 16);
    chk("t2_full", 32'(bus.full), 1);
    chk("t2_no_ovf_yet", 32'(bus.overflow), 0);
    tick(1);
    wr_byte(8'h10);
    @(negedge clk);
    chk("t2_ovf_set", 32'(bus.overflow), 1);
    tick(1);
    bus.ovfClear = 1'b1;
    tick(1);
    bus.ovfClear = 1'b0;
    @(negedge clk);
    chk("t2_ovf_cleared", 32'(bus.overflow), 0);
    tick(1);
    bus.ovfClear = 1'b1; bus.wrEn = 1'b1; bus.wrData = 8'h11;
    tick(1);
    bus.ovfClear = 1'b0; bus.wrEn = 1'b0;
    @(negedge clk);
    chk("t2_set_beats_clear", 32'(bus.overflow), 1);
    tick(1);
    bus.ovfClear = 1'b1;
    tick(1);
    bus.ovfClear = 1'b0;
    resp_delay = 1; resp_hold = 5; mode = M_ACK;
    wait_idle("t2", 1500);

    // ordering of three acknowledged bytes
    t0 = n_trig;
    wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
    wait_idle("t3", 500);
    chk("t3_trig_count", 32'(n_trig - t0), 3);

    // start-acknowledge timeout, then the next byte still goes out
    mode = M_NOACK;
    t0 = n_ack;
    wr_byte(8'h44); wr_byte(8'h55);
    n = 0;
    while (n_ack - t0 < 2 && n < 200) begin tick(1); n++; end
    tick(3);
    chk("t4_ack_count", 32'(n_ack - t0), 2);
    chk("t4_back_idle", 32'(bus.busy), 0);
    mode = M_ACK;
    wr_byte(8'h66);
    wait_idle("t4", 300);

    // reset during WAIT_DONE with the frame still running
    resp_delay = 1; resp_hold = 40;
    wr_byte(8'h77); wr_byte(8'h88); wr_byte(8'h99);
    n = 0;
    while (!bus.txStatus && n < 50) begin tick(1); n++; end
    tick(6);
    chk("t5_in_frame", 32'(bus.busy && bus.txStatus), 1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    t0 = n_trig;
    wr_byte(8'hAA);
    n = 0;
    while (bus.txStatus && n < 100) begin tick(1); n++; end
    chk("t5_no_trig_while_status", 32'(n_trig - t0), 0);
    wait_idle("t5", 500);
    chk("t5_trig_after_release", 32'(n_trig - t0), 1);

    // simultaneous write and pop at level 1
    resp_hold = 5;
    mode = M_HOLD;
    tick(4);
    wr_byte(8'hC1);
    tick(1);
    mode = M_ACK;
    tick(2);
    bus.wrEn = 1'b1; bus.wrData = 8'hC2;
    tick(1);
    bus.wrEn = 1'b0;
    @(negedge clk);
    chk("t6_level_kept", 32'(bus.level), 1);
    chk("t6_trig", 32'(bus.txTrigger), 1);
    chk("t6_head_data", 32'(bus.txParallelData), 32'h C1);
    tick(1);
    wait_idle("t6", 300);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 16 == 0) begin
        resp_delay = ($urandom_range(0, 9) == 0) ? 25 : int'($urandom_range(0, 3));
        resp_hold  = int'($urandom_range(1, 12));
      end
      bus.wrEn     = ($urandom_range(0, 7) == 0);
      bus.wrData   = 8'($urandom);
      bus.ovfClear = ($urandom_range(0, 63) == 0);
      tick(1);
    end
    bus.wrEn = 1'b0;
    bus.ovfClear = 1'b0;
    wait_idle("stress", 3000);
    chk("stress_queue_empty", 32'(exp_q.size()), 0);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
